// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin owner of the shared modulo/compare ALU.
// One requester at a time is granted; the owner keeps the ALU until it
// drops its request, and the owner's command is muxed onto the ALU.
// A handover always passes through one idle cycle so the ALU operand mux
// switches cleanly.
// Optional feature: define ALU_ARB_PREEMPT_EN to compile in the hold counter
// and forced release. Under contention, an unlocked owner that has held the
// ALU for MAX_HOLD cycles is then released.
module alu_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MODE_W   = 3,
  parameter int MAX_HOLD = 16,
  localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        lock_i,
  input  logic [N_REQ*MODE_W-1:0] mode_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [OW-1:0]           owner_o,
  output logic                    busy_o,
  output logic [MODE_W-1:0]       alu_mode_o,
  output logic                    preempt_o
);

  localparam logic [MODE_W-1:0] ALU_IDLE = MODE_W'(2);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   w_gnt_next;
  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      w_owner_next;
  logic [OW-1:0]      r_last;
  logic [OW-1:0]      w_last_next;

  // Round-robin search: the requesters above the last owner are
  // candidates first. If none is found, the search wraps to the lowest
  // requester.
  logic [N_REQ-1:0]   w_above;
  logic [OW-1:0]      w_pick_hi;
  logic [OW-1:0]      w_pick_lo;
  logic [OW-1:0]      w_pick;
  logic [N_REQ-1:0]   w_pick_oh;
  logic               w_any_req;

  // Per-requester command slices for the ALU mux.
  logic [MODE_W-1:0]  w_mode_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_above[gi]    = req_i[gi] && (OW'(gi) > r_last);
      assign w_mode_arr[gi] = mode_i[gi*MODE_W +: MODE_W];
    end
  endgenerate

  assign w_any_req = |req_i;

  // Lowest set bit of each candidate set; a descending scan lets the lowest index win.
  always_comb begin
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_above[i]) w_pick_hi = OW'(i);
      if (req_i[i])   w_pick_lo = OW'(i);
    end
    w_pick    = (|w_above) ? w_pick_hi : w_pick_lo;
    w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  end

`ifdef ALU_ARB_PREEMPT_EN
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD - 1);

  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_next;
  logic          r_preempt;
  logic          w_preempt_next;
  logic          w_other_req;

  // While OWNED, r_gnt holds only the owner's bit, so any remaining request belongs to another requester.
  assign w_other_req = |(req_i & ~r_gnt);
`else
  // Without preemption, lock and hold limit have no effect.
  logic w_unused;
  assign w_unused = (^lock_i) ^ (MAX_HOLD < 2);
`endif

  // Next-state and grant decisions for the IDLE/OWNED state machine.
  always_comb begin
    w_state_next   = r_state;
    w_gnt_next     = r_gnt;
    w_owner_next   = r_owner;
    w_last_next    = r_last;
`ifdef ALU_ARB_PREEMPT_EN
    w_hold_next    = r_hold;
    w_preempt_next = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_gnt_next   = w_pick_oh;
          w_owner_next = w_pick;
          w_last_next  = w_pick;
          w_state_next = S_OWNED;
`ifdef ALU_ARB_PREEMPT_EN
          w_hold_next  = '0;
`endif
        end
      end
      S_OWNED: begin
        if (!req_i[r_owner]) begin
          // Normal release. r_last already names this owner, so it gets
          // the lowest priority in the next search.
          w_gnt_next   = '0;
          w_state_next = S_IDLE;
`ifdef ALU_ARB_PREEMPT_EN
        end else if ((r_hold == HOLD_SAT) && w_other_req && !lock_i[r_owner]) begin
          w_gnt_next     = '0;
          w_state_next   = S_IDLE;
          w_preempt_next = 1'b1;
        end else if (r_hold != HOLD_SAT) begin
          w_hold_next = r_hold + HW'(1);
`endif
        end
      end
      default: begin
        w_gnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; asynchronous reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= OW'(N_REQ - 1);
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
    end
  end

`ifdef ALU_ARB_PREEMPT_EN
  // Hold counter and forced-release pulse.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_preempt <= w_preempt_next;
    end
  end

  assign preempt_o = r_preempt;
`else
  assign preempt_o = 1'b0;
`endif

  assign gnt_o      = r_gnt;
  assign owner_o    = r_owner;
  assign busy_o     = |r_gnt;
  // The mux is not registered, so the ALU sees the owner's command in the same cycle.
  assign alu_mode_o = busy_o ? w_mode_arr[r_owner] : ALU_IDLE;

endmodule
